// File: rtl/work_transmit.sv
// work_transmit: UART 8N1 serialiser for one 84-byte work packet {target, data3, data2, data1},
// least significant byte first, with an optional idle gap before the done pulse.
module work_transmit #(
    parameter int comm_clk_frequency = 100_000_000,
    parameter int baud_rate = 115_200,
    parameter int GAP_BITS = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [255:0] data1,
    input  logic [255:0] data2,
    input  logic [127:0] data3,
    input  logic [31:0]  target,
    output logic         TxD,
    output logic         busy,
    output logic         done
);
    localparam int DIV = comm_clk_frequency / baud_rate;
    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_BITS - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP, DONE} state_t;
    state_t state, state_n;
    logic [15:0] timer, timer_n, gap_cnt, gap_n;
    logic [2:0] idx, idx_n;
    logic [6:0] cnt, cnt_n;
    logic [671:0] sh, sh_n;
    logic bit_end, tx_n;
    assign bit_end = timer == DIV_LAST;
    always_comb begin
        state_n = state;
        timer_n = bit_end ? 16'd0 : timer + 16'd1;
        gap_n = gap_cnt;
        idx_n = idx;
        cnt_n = cnt;
        sh_n = sh;
        case (state)
            IDLE: begin
                timer_n = 16'd0;
                if (start) begin
                    sh_n = {target, data3, data2, data1};
                    cnt_n = 7'd0;
                    state_n = START;
                end
            end
            START: if (bit_end) begin
                idx_n = 3'd0;
                state_n = DATA;
            end
            DATA: if (bit_end) begin
                idx_n = idx + 3'd1;
                state_n = idx == 3'd7 ? STOP : DATA;
            end
            STOP: if (bit_end) begin
                if (cnt < 7'd83) begin
                    cnt_n = cnt + 7'd1;
                    sh_n = sh >> 8;
                    state_n = START;
                end else begin
                    gap_n = 16'd0;
                    state_n = GAP_BITS > 0 ? GAP : DONE;
                end
            end
            GAP: if (bit_end) begin
                gap_n = gap_cnt + 16'd1;
                state_n = gap_cnt == GAP_LAST ? DONE : GAP;
            end
            DONE: begin
                timer_n = 16'd0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    // Outputs are decoded from the next state so they change on the same edge as the state register.
    assign tx_n = state_n == START ? 1'b0 : state_n == DATA ? sh_n[idx_n] : 1'b1;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            timer <= 16'd0;
            gap_cnt <= 16'd0;
            idx <= 3'd0;
            cnt <= 7'd0;
            sh <= '0;
            TxD <= 1'b1;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= state_n;
            timer <= timer_n;
            gap_cnt <= gap_n;
            idx <= idx_n;
            cnt <= cnt_n;
            sh <= sh_n;
            TxD <= tx_n;
            busy <= state_n inside {START, DATA, STOP, GAP};
            done <= state_n == DONE;
        end
    end
endmodule

// File: tb/tb_work_transmit.sv
// tb_work_transmit: table of packets sent through work_transmit, decoded by a UART monitor
// and compared byte by byte against a scoreboard queue; hand sequences cover timing corners.
module tb_work_transmit;
    localparam int DIV = 16;
    localparam int PKT = 840 * DIV;
    localparam int GAPC = 3 * DIV;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [255:0] data1 = '0, data2 = '0;
    logic [127:0] data3 = '0;
    logic [31:0] target = '0;
    logic tx0, busy0, done0, tx1, busy1, done1;
    int cyc = 0, checks = 0, failures = 0;
    int n, bad;
    typedef struct {
        logic [255:0] d1;
        logic [255:0] d2;
        logic [127:0] d3;
        logic [31:0] tg;
        logic [7:0] first;
        logic [7:0] last;
    } vec_t;
    vec_t vecs[4];
    logic [7:0] q[$];
    int mon_t = -1, mon_cnt = 0;
    logic [7:0] mon_byte, mon_first, mon_last, e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    work_transmit #(.comm_clk_frequency(16), .baud_rate(1), .GAP_BITS(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .data1(data1), .data2(data2), .data3(data3),
        .target(target), .TxD(tx0), .busy(busy0), .done(done0));
    work_transmit #(.comm_clk_frequency(16), .baud_rate(1), .GAP_BITS(3)) dut1 (
        .clk(clk), .reset(reset), .start(start), .data1(data1), .data2(data2), .data3(data3),
        .target(target), .TxD(tx1), .busy(busy1), .done(done1));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // UART monitor: samples mid-bit from the first low cycle of each start bit.
    always @(negedge clk) begin
        if (reset) begin
            mon_t = -1;
            q.delete();
        end else if (mon_t < 0) begin
            if (tx0 === 1'b0) mon_t = 0;
        end else begin
            mon_t++;
            if (mon_t == DIV / 2) chk("start_bit", 64'(tx0), 64'd0);
            else if (mon_t > DIV && mon_t < 9 * DIV && mon_t % DIV == DIV / 2)
                mon_byte[3'(mon_t / DIV - 1)] = tx0;
            else if (mon_t == 9 * DIV + DIV / 2) begin
                chk("stop_bit", 64'(tx0), 64'd1);
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte: got %h expected no byte (cycle %0d)", mon_byte, cyc);
                end else begin
                    e = q.pop_front();
                    chk("byte", 64'(mon_byte), 64'(e));
                end
                if (mon_cnt == 0) mon_first = mon_byte;
                mon_last = mon_byte;
                mon_cnt++;
                mon_t = -1;
            end
        end
    end

    task automatic load(input int i);
        logic [671:0] pk;
        data1 = vecs[i].d1;
        data2 = vecs[i].d2;
        data3 = vecs[i].d3;
        target = vecs[i].tg;
        pk = {vecs[i].tg, vecs[i].d3, vecs[i].d2, vecs[i].d1};
        for (int b = 0; b < 84; b++) q.push_back(pk[b*8 +: 8]);
        mon_cnt = 0;
    endtask

    task automatic kick(output int c);
        @(negedge clk);
        start = 1'b1;
        c = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("tx_fall", 64'(tx0), 64'd0);
        chk("busy_rise", 64'(busy0), 64'd1);
    endtask

    task automatic wait_done(input int exp_cyc, input string name);
        for (int k = 0; k < PKT + 200 && done0 !== 1'b1; k++) @(negedge clk);
        chk(name, 64'(cyc), 64'(exp_cyc));
        chk("busy_at_done", 64'(busy0), 64'd0);
    endtask

    task automatic check_pkt(input int i);
        chk("nbytes", 64'(mon_cnt), 64'd84);
        chk("first_byte", 64'(mon_first), 64'(vecs[i].first));
        chk("last_byte", 64'(mon_last), 64'(vecs[i].last));
        chk("queue_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        vecs[0] = '{256'hA5, 256'h0, 128'h0, 32'h0, 8'hA5, 8'h00};
        vecs[1] = '{256'h0, 256'h0, 128'h0, 32'hDEADBEEF, 8'h00, 8'hDE};
        vecs[2] = '{{8{32'h01234567}}, {8{32'h89ABCDEF}}, {4{32'hCAFEF00D}}, 32'h12345678, 8'h67, 8'h12};
        vecs[3] = '{{256{1'b1}}, {256{1'b1}}, {128{1'b1}}, {32{1'b1}}, 8'hFF, 8'hFF};
        repeat (5) @(negedge clk);
        chk("reset_tx", 64'(tx0), 64'd1);
        chk("reset_busy", 64'(busy0), 64'd0);
        chk("reset_done", 64'(done0), 64'd0);
        reset = 1'b0;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) bad++;
        end
        chk("idle_line", 64'(bad), 64'd0);
        // Packet 0: a start with different data mid-packet must be ignored; dut1 adds a 3-bit gap.
        load(0);
        kick(n);
        repeat (490) @(negedge clk);
        data1 = vecs[3].d1;
        data3 = vecs[3].d3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n + 1 + PKT, "done_cycle_pkt0");
        check_pkt(0);
        bad = 0;
        repeat (GAPC) begin
            if (tx1 !== 1'b1 || busy1 !== 1'b1 || done1 !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("gap_line", 64'(bad), 64'd0);
        chk("gap_done", 64'(done1), 64'd1);
        chk("gap_busy", 64'(busy1), 64'd0);
        // Packet 1, then packet 2 with start held across the done cycle.
        load(1);
        kick(n);
        wait_done(n + 1 + PKT, "done_cycle_pkt1");
        check_pkt(1);
        load(2);
        start = 1'b1;
        @(negedge clk);
        chk("start_in_done_ignored_tx", 64'(tx0), 64'd1);
        chk("start_in_done_ignored_busy", 64'(busy0), 64'd0);
        n = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_tx_fall", 64'(tx0), 64'd0);
        chk("b2b_busy", 64'(busy0), 64'd1);
        wait_done(n + 1 + PKT, "done_cycle_pkt2");
        check_pkt(2);
        // Reset mid-byte abandons the packet; a fresh packet follows.
        load(3);
        kick(n);
        repeat (2990) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_tx", 64'(tx0), 64'd1);
        chk("midreset_busy", 64'(busy0), 64'd0);
        chk("midreset_done", 64'(done0), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (DIV * 20) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) bad++;
        end
        chk("post_reset_idle", 64'(bad), 64'd0);
        load(3);
        kick(n);
        wait_done(n + 1 + PKT, "done_cycle_pkt3");
        check_pkt(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end
endmodule
